// File: rtl/gshare_ongoru_birimi.sv
// gshare branch direction predictor.
// A table of CTR_W-bit saturating counters is indexed by PC XOR global history
// (MODE 0) or by PC alone (MODE 1). Predictions are issued on the predict port
// and each carries its table index and history checkpoint. Resolved branches
// come back on the update port with those values. A mispredict rebuilds the
// history from the checkpoint plus the real outcome.
//
// Handshake: there is no back-pressure. A request is accepted on every rising
// edge where its valid input is high. o_tahmin_gecerli is a one-cycle
// registered strobe for each accepted predict. o_ongoru_yanlis is a one-cycle
// registered strobe for each mispredicted update.
module gshare_ongoru_birimi #(
    parameter int IDX_W  = 5,
    parameter int HIST_W = 5,
    parameter int CTR_W  = 2,
    parameter int MODE   = 0
) (
    input  logic              i_saat,
    input  logic              i_reset,
    input  logic              i_tahmin_gecerli,
    input  logic [31:0]       i_buyruk_sayaci,
    output logic              o_tahmin_gecerli,
    output logic              o_buyruk_ongoru,
    output logic [IDX_W-1:0]  o_ongoru_indeks,
    output logic [HIST_W-1:0] o_gecmis,
    input  logic              i_guncelle_gecerli,
    input  logic [IDX_W-1:0]  i_guncelle_indeks,
    input  logic [HIST_W-1:0] i_guncelle_gecmis,
    input  logic              i_ongoru,
    input  logic              i_buyruk_atladi,
    output logic              o_ongoru_yanlis,
    output logic [31:0]       o_tahmin_sayisi,
    output logic [31:0]       o_yanlis_sayisi
);

    localparam int DERINLIK = 1 << IDX_W;
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_W-1:0] ZAYIF_ALMAZ = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] SAYAC_UST   = {CTR_W{1'b1}};

    logic [CTR_W-1:0]  tablo [DERINLIK];
    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_kaydir;
    logic [HIST_W-1:0] ghr_onar;
    logic [IDX_W-1:0]  pc_idx;
    logic [IDX_W-1:0]  idx;
    logic              tahmin_bit;
    logic              yanlis;
    logic              unused_pc;

    assign pc_idx    = i_buyruk_sayaci[IDX_W+1:2];
    assign unused_pc = ^{i_buyruk_sayaci[31:IDX_W+2], i_buyruk_sayaci[1:0]};

    // Bimodal ignores history for indexing but still keeps the GHR running.
    generate
        if (MODE == 1) begin : g_bimodal
            assign idx = pc_idx;
        end else begin : g_gshare
            assign idx = pc_idx ^ IDX_W'(ghr);
        end
    endgenerate

    assign tahmin_bit = tablo[idx][CTR_W-1];
    assign yanlis     = i_guncelle_gecerli && (i_ongoru != i_buyruk_atladi);

    // A one-bit history has nothing to shift, so it simply becomes the new bit.
    generate
        if (HIST_W == 1) begin : g_gecmis_tek
            assign ghr_kaydir = tahmin_bit;
            assign ghr_onar   = i_buyruk_atladi;
        end else begin : g_gecmis_cok
            assign ghr_kaydir = {ghr[HIST_W-2:0], tahmin_bit};
            assign ghr_onar   = {i_guncelle_gecmis[HIST_W-2:0], i_buyruk_atladi};
        end
    endgenerate

    // Pattern table: only the update port writes it. The predict path reads
    // the value from before the edge, so no bypass is applied.
    always_ff @(posedge i_saat) begin
        if (!i_reset) begin
            for (int i = 0; i < DERINLIK; i++) begin
                tablo[i] <= ZAYIF_ALMAZ;
            end
        end else if (i_guncelle_gecerli) begin
            if (i_buyruk_atladi) begin
                if (tablo[i_guncelle_indeks] != SAYAC_UST) begin
                    tablo[i_guncelle_indeks] <= tablo[i_guncelle_indeks] + 1'b1;
                end
            end else if (tablo[i_guncelle_indeks] != '0) begin
                tablo[i_guncelle_indeks] <= tablo[i_guncelle_indeks] - 1'b1;
            end
        end
    end

    // History and prediction outputs. A mispredict restore wins over the
    // speculative shift, because that predict is on the wrong path.
    always_ff @(posedge i_saat) begin
        if (!i_reset) begin
            ghr              <= '0;
            o_tahmin_gecerli <= 1'b0;
            o_buyruk_ongoru  <= 1'b0;
            o_ongoru_indeks  <= '0;
            o_gecmis         <= '0;
            o_ongoru_yanlis  <= 1'b0;
        end else begin
            o_tahmin_gecerli <= i_tahmin_gecerli;
            o_ongoru_yanlis  <= yanlis;
            if (i_tahmin_gecerli) begin
                o_buyruk_ongoru <= tahmin_bit;
                o_ongoru_indeks <= idx;
                o_gecmis        <= ghr;
            end
            if (yanlis) begin
                ghr <= ghr_onar;
            end else if (i_tahmin_gecerli) begin
                ghr <= ghr_kaydir;
            end
        end
    end

    // Statistics counters stop at all-ones instead of wrapping.
    always_ff @(posedge i_saat) begin
        if (!i_reset) begin
            o_tahmin_sayisi <= '0;
            o_yanlis_sayisi <= '0;
        end else begin
            if (i_tahmin_gecerli && (o_tahmin_sayisi != '1)) begin
                o_tahmin_sayisi <= o_tahmin_sayisi + 32'd1;
            end
            if (yanlis && (o_yanlis_sayisi != '1)) begin
                o_yanlis_sayisi <= o_yanlis_sayisi + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_ongoru_birimi.sv
// Testbench for gshare_ongoru_birimi: one gshare instance and one bimodal
// instance share the same stimulus and are compared against a reference model.
module tb_gshare_ongoru_birimi;

    localparam int VW = 77;  // {tv, pred, idx[5], gec[5], yanlis, tcnt[32], ycnt[32]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tv;
    logic [31:0] pc;
    logic        uv;
    logic [4:0]  uidx;
    logic [4:0]  ugec;
    logic        ong;
    logic        atl;

    logic        a_tv, a_pred, a_yan, b_tv, b_pred, b_yan;
    logic [4:0]  a_idx, a_gec, b_idx, b_gec;
    logic [31:0] a_tc, a_yc, b_tc, b_yc;

    gshare_ongoru_birimi #(.IDX_W(5), .HIST_W(5), .CTR_W(2), .MODE(0)) dut_a (
        .i_saat(clk), .i_reset(rst_n),
        .i_tahmin_gecerli(tv), .i_buyruk_sayaci(pc),
        .o_tahmin_gecerli(a_tv), .o_buyruk_ongoru(a_pred),
        .o_ongoru_indeks(a_idx), .o_gecmis(a_gec),
        .i_guncelle_gecerli(uv), .i_guncelle_indeks(uidx),
        .i_guncelle_gecmis(ugec), .i_ongoru(ong), .i_buyruk_atladi(atl),
        .o_ongoru_yanlis(a_yan), .o_tahmin_sayisi(a_tc), .o_yanlis_sayisi(a_yc)
    );

    gshare_ongoru_birimi #(.IDX_W(5), .HIST_W(5), .CTR_W(2), .MODE(1)) dut_b (
        .i_saat(clk), .i_reset(rst_n),
        .i_tahmin_gecerli(tv), .i_buyruk_sayaci(pc),
        .o_tahmin_gecerli(b_tv), .o_buyruk_ongoru(b_pred),
        .o_ongoru_indeks(b_idx), .o_gecmis(b_gec),
        .i_guncelle_gecerli(uv), .i_guncelle_indeks(uidx),
        .i_guncelle_gecmis(ugec), .i_ongoru(ong), .i_buyruk_atladi(atl),
        .o_ongoru_yanlis(b_yan), .o_tahmin_sayisi(b_tc), .o_yanlis_sayisi(b_yc)
    );

    // ---------------- reference model (index 0 = gshare, 1 = bimodal) -------
    int     m_tab [2][32];
    int     m_ghr [2];
    longint m_tc  [2];
    longint m_yc  [2];
    bit     m_tv  [2];
    bit     m_pred[2];
    bit     m_yan [2];
    int     m_idx [2];
    int     m_gec [2];

    task automatic model_step(input int m);
        int idx;
        int ng;
        bit p;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_tab[m][i] = 1;
            m_ghr[m] = 0; m_tc[m] = 0; m_yc[m] = 0;
            m_tv[m] = 0; m_pred[m] = 0; m_yan[m] = 0; m_idx[m] = 0; m_gec[m] = 0;
            return;
        end
        ng = m_ghr[m];
        if (tv) begin
            if (m == 1) idx = int'(pc / 4) % 32;
            else        idx = (int'(pc / 4) % 32) ^ m_ghr[m];
            p = (m_tab[m][idx] >= 2);
            m_tv[m] = 1; m_pred[m] = p; m_idx[m] = idx; m_gec[m] = m_ghr[m];
            ng = (m_ghr[m] * 2 + int'(p)) % 32;
            if (m_tc[m] < 64'hFFFF_FFFF) m_tc[m]++;
        end else begin
            m_tv[m] = 0;
        end
        m_yan[m] = 0;
        if (uv) begin
            if (atl) m_tab[m][uidx] = (m_tab[m][uidx] < 3) ? m_tab[m][uidx] + 1 : 3;
            else     m_tab[m][uidx] = (m_tab[m][uidx] > 0) ? m_tab[m][uidx] - 1 : 0;
            if (ong != atl) begin
                ng = (int'(ugec) * 2 + int'(atl)) % 32;
                m_yan[m] = 1;
                if (m_yc[m] < 64'hFFFF_FFFF) m_yc[m]++;
            end
        end
        m_ghr[m] = ng;
    endtask

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit t, input logic [31:0] p, input bit u,
                         input logic [4:0] ui, input logic [4:0] ug, input bit o, input bit a);
        rst_n = r; tv = t; pc = p; uv = u; uidx = ui; ugec = ug; ong = o; atl = a;
    endtask

    // Advance one clock with the current inputs and check both DUTs vs the model.
    task automatic run_cycle(input string tag);
        logic [VW-1:0] e;
        for (int m = 0; m < 2; m++) begin
            model_step(m);
            exp_q.push_back({m_tv[m], m_pred[m], 5'(m_idx[m]), 5'(m_gec[m]), m_yan[m],
                             32'(m_tc[m]), 32'(m_yc[m])});
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "/gshare"}, {a_tv, a_pred, a_idx, a_gec, a_yan, a_tc, a_yc}, e);
        e = exp_q.pop_front();
        chk({tag, "/bimodal"}, {b_tv, b_pred, b_idx, b_gec, b_yan, b_tc, b_yc}, e);
    endtask

    // ---------------- directed vector table (gshare instance) ----------------
    typedef struct {
        bit          rst_n, tv;
        logic [31:0] pc;
        bit          uv;
        logic [4:0]  uidx, ugec;
        bit          ong, atl;
        bit          e_tv, e_pred;
        logic [4:0]  e_idx, e_gec;
        bit          e_yan;
        logic [31:0] e_tc, e_yc;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(bit r, bit t, logic [31:0] p, bit u, logic [4:0] ui,
                                logic [4:0] ug, bit o, bit a, bit etv, bit ep,
                                logic [4:0] ei, logic [4:0] eg, bit ey, int etc_, int eyc);
        vec_t v;
        v.rst_n = r; v.tv = t; v.pc = p; v.uv = u; v.uidx = ui; v.ugec = ug;
        v.ong = o; v.atl = a; v.e_tv = etv; v.e_pred = ep; v.e_idx = ei; v.e_gec = eg;
        v.e_yan = ey; v.e_tc = 32'(etc_); v.e_yc = 32'(eyc);
        return v;
    endfunction

    initial begin
        logic [VW-1:0] act_v;
        logic [VW-1:0] exp_v;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset; first predict; saturating increments; decrements; mispredict
        // restore; same-cycle predict+update; reset over in-flight traffic.
        vt[0]  = mk(0,0,32'h00,0,5'h00,5'h00,0,0, 0,0,5'h00,5'h00,0,0,0);
        vt[1]  = mk(1,1,32'h40,0,5'h00,5'h00,0,0, 1,0,5'h10,5'h00,0,1,0);
        for (int i = 2; i <= 5; i++)
            vt[i] = mk(1,0,32'h00,1,5'h03,5'h00,1,1, 0,0,5'h10,5'h00,0,1,0);
        vt[6]  = mk(1,1,32'h0C,0,5'h00,5'h00,0,0, 1,1,5'h03,5'h00,0,2,0);
        for (int i = 7; i <= 11; i++)
            vt[i] = mk(1,0,32'h00,1,5'h03,5'h00,0,0, 0,1,5'h03,5'h00,0,2,0);
        vt[12] = mk(1,0,32'h00,1,5'h00,5'h06,0,1, 0,1,5'h03,5'h00,1,2,1);
        vt[13] = mk(1,1,32'h00,0,5'h00,5'h00,0,0, 1,0,5'h0D,5'h0D,0,3,1);
        vt[14] = mk(1,1,32'h00,1,5'h1A,5'h00,1,1, 1,0,5'h1A,5'h1A,0,4,1);
        vt[15] = mk(1,1,32'h38,0,5'h00,5'h00,0,0, 1,1,5'h1A,5'h14,0,5,1);
        vt[16] = mk(0,1,32'h0C,1,5'h05,5'h03,0,1, 0,0,5'h00,5'h00,0,0,0);
        vt[17] = mk(1,1,32'h68,0,5'h00,5'h00,0,0, 1,0,5'h1A,5'h00,0,1,0);

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].rst_n, vt[i].tv, vt[i].pc, vt[i].uv, vt[i].uidx, vt[i].ugec,
                  vt[i].ong, vt[i].atl);
            run_cycle($sformatf("vec%0d_model", i));
            act_v = {a_tv, a_pred, a_idx, a_gec, a_yan, a_tc, a_yc};
            exp_v = {vt[i].e_tv, vt[i].e_pred, vt[i].e_idx, vt[i].e_gec, vt[i].e_yan,
                     vt[i].e_tc, vt[i].e_yc};
            chk($sformatf("vec%0d_table", i), act_v, exp_v);
        end

        // Bimodal: history shifts but the index stays PC-only; restore still works.
        drive(0, 0, 0, 0, 0, 0, 0, 0);                  run_cycle("b_rst");
        drive(1, 0, 0, 1, 5'h10, 0, 1, 1);              run_cycle("b_up1");
        run_cycle("b_up2");
        drive(1, 1, 32'h40, 0, 0, 0, 0, 0);             run_cycle("b_p1");
        chk("b_p1_pred", VW'(b_pred), VW'(1));
        run_cycle("b_p2");
        chk("b_p2_idx", VW'(b_idx), VW'(5'h10));
        chk("b_p2_gec", VW'(b_gec), VW'(5'h01));
        drive(1, 0, 0, 1, 5'h00, 5'b00110, 0, 1);       run_cycle("b_mis");
        chk("b_mis_pulse", VW'(b_yan), VW'(1));
        drive(1, 1, 32'h00, 0, 0, 0, 0, 0);             run_cycle("b_p3");
        chk("b_p3_gec", VW'(b_gec), VW'(5'b01101));
        chk("b_p3_pulse_off", VW'(b_yan), VW'(0));

        // Randomized traffic; small index range concentrates saturation hits.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_cycle($sformatf("rnd%0d", n));
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
